// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic units (multiplier and divider).
// Holds the control FSM encoding and the default operand width.
package arith_pkg;

    localparam int ARITH_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } arith_state_t;

endpackage

// File: rtl/mul_aq_shifter.sv
// A/Q/M datapath of the shift-add multiplier: loads operands, then per enabled cycle adds M when Q[0]=1 and shifts {A,Q} right.
// One iteration per enabled clock; no backpressure, the FSM in the parent decides when to load or shift.
module mul_aq_shifter
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift_en,
    input  logic [WIDTH-1:0]   m_in,
    input  logic [WIDTH-1:0]   q_in,
    output logic [2*WIDTH-1:0] prod_nxt
);

    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   a_shift;
    logic [WIDTH-1:0] q_shift;

    // A is one bit wider than M so the carry of the add survives into the shift.
    always_comb begin
        sum      = a_q + (q_q[0] ? {1'b0, m_q} : '0);
        a_shift  = {1'b0, sum[WIDTH:1]};
        q_shift  = {sum[0], q_q[WIDTH-1:1]};
        prod_nxt = {a_shift[WIDTH-1:0], q_shift};
    end

    always_comb begin
        a_d = a_q;
        q_d = q_q;
        m_d = m_q;
        if (load) begin
            a_d = '0;
            q_d = q_in;
            m_d = m_in;
        end else if (shift_en) begin
            a_d = a_shift;
            q_d = q_shift;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q <= '0;
            q_q <= '0;
            m_q <= '0;
        end else begin
            a_q <= a_d;
            q_q <= q_d;
            m_q <= m_d;
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned WIDTH x WIDTH sequential shift-add multiplier with start/busy/done handshake.
// Latency WIDTH+1 cycles from accepted start to done; start is ignored while busy, accepted in IDLE or DONE.
module seq_multiplier
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam int CW = $clog2(WIDTH + 1);

    arith_state_t      state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic               load;
    logic               shift_en;
    logic               last_iter;
    logic [2*WIDTH-1:0] prod_nxt;

    mul_aq_shifter #(.WIDTH(WIDTH)) u_aq (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (shift_en),
        .m_in     (multiplicand),
        .q_in     (multiplier),
        .prod_nxt (prod_nxt)
    );

    assign last_iter = (count_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? CALC : IDLE;
            CALC:    state_d = last_iter ? DONE : CALC;
            DONE:    state_d = start ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == CALC);
        done     = (state_q == DONE);
        shift_en = (state_q == CALC);
        load     = (state_q != CALC) && start;
    end

    // Product register only moves on the completing iteration so it holds between results.
    always_comb begin
        count_d   = count_q;
        product_d = product_q;
        if (load) begin
            count_d = '0;
        end else if (shift_en) begin
            count_d = count_q + 1'b1;
            if (last_iter) begin
                product_d = prod_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            product_q <= '0;
        end else begin
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier with a cycle-level reference model and per-cycle output comparison.
module tb_seq_multiplier;

    localparam int W = 16;
    localparam int LAT = W + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: an accepted request finishes exactly W cycles of work later, then shows done for one cycle.
    int             m_left = 0;
    logic           m_busy = 1'b0;
    logic           m_done = 1'b0;
    logic [2*W-1:0] m_prod = '0;
    logic [2*W-1:0] m_pending = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left = 0; m_busy = 1'b0; m_done = 1'b0; m_prod = '0; m_pending = '0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            m_busy = (m_left > 0);
            if (m_left == 0) begin
                m_done = 1'b1;
                m_prod = m_pending;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_pending = {{W{1'b0}}, multiplicand} * {{W{1'b0}}, multiplier};
                m_left = W;
                m_busy = 1'b1;
            end else begin
                m_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("busy_vs_model", 64'(busy), 64'(m_busy));
            check("done_vs_model", 64'(done), 64'(m_done));
            check("product_vs_model", 64'(product), 64'(m_prod));
            if (busy && done) check("busy_done_exclusive", 64'(1), 64'(0));
        end
    end

    task automatic wait_done(output int dc, output logic ok);
        ok = 1'b0;
        dc = 0;
        for (int i = 0; i < 3 * LAT; i++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp);
        int sc, dc;
        logic ok;
        @(posedge clk); #1;
        sc = cyc;
        start = 1'b1; multiplicand = a; multiplier = b;
        @(posedge clk); #1;
        start = 1'b0;
        multiplicand = W'($urandom); multiplier = W'($urandom);
        wait_done(dc, ok);
        check({name, "_done_seen"}, 64'(ok), 64'(1));
        check({name, "_latency"}, 64'(dc - sc), 64'(LAT));
        check({name, "_product"}, 64'(product), 64'(exp));
    endtask

    initial begin
        int sc, dc, n_done, first_dc;
        logic ok, held;
        logic [2*W-1:0] first_prod;

        #2 rst = 1'b0;
        #1;
        check("reset_product", 64'(product), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        run_op("basic_3x5", 16'd3, 16'd5, 32'h0000_000F);
        run_op("max_sq", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        run_op("carry_8000x2", 16'h8000, 16'h0002, 32'h0001_0000);
        run_op("zero", 16'h0000, 16'h1234, 32'h0000_0000);
        run_op("identity", 16'h1234, 16'h0001, 32'h0000_1234);

        // Restart attempt during CALC must be ignored.
        @(posedge clk); #1;
        sc = cyc;
        start = 1'b1; multiplicand = 16'd7; multiplier = 16'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; multiplicand = 16'd2; multiplier = 16'd2;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0; first_dc = 0; first_prod = '0;
        while (cyc < sc + 40) begin
            @(negedge clk);
            if (done) begin
                if (n_done == 0) begin
                    first_dc = cyc;
                    first_prod = product;
                end
                n_done++;
            end
        end
        check("ignore_start_done_count", 64'(n_done), 64'(1));
        check("ignore_start_latency", 64'(first_dc - sc), 64'(LAT));
        check("ignore_start_product", 64'(first_prod), 64'(63));

        // Asynchronous reset in the middle of CALC.
        @(posedge clk); #1;
        sc = cyc;
        start = 1'b1; multiplicand = 16'd50; multiplier = 16'd60;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_done", 64'(done), 64'(0));
        check("midreset_product", 64'(product), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        run_op("after_reset", 16'd100, 16'd200, 32'd20000);

        // Back-to-back: start held high, new operands presented in the DONE cycle.
        @(posedge clk); #1;
        sc = cyc;
        start = 1'b1; multiplicand = 16'd10; multiplier = 16'd10;
        wait_done(dc, ok);
        check("b2b_first_seen", 64'(ok), 64'(1));
        check("b2b_first_latency", 64'(dc - sc), 64'(LAT));
        check("b2b_first_product", 64'(product), 64'(100));
        multiplicand = 16'hABCD; multiplier = 16'h0100;
        sc = dc;
        @(posedge clk); #1;
        start = 1'b0;
        held = 1'b1; ok = 1'b0; dc = 0;
        for (int i = 0; i < 3 * LAT; i++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                ok = 1'b1;
                break;
            end
            if (product !== 32'd100) held = 1'b0;
        end
        check("b2b_product_held", 64'(held), 64'(1));
        check("b2b_second_seen", 64'(ok), 64'(1));
        check("b2b_spacing", 64'(dc - sc), 64'(LAT));
        check("b2b_second_product", 64'(product), 64'h0000_0000_00AB_CD00);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
